multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Debounces NUM_CH asynchronous push-button/switch inputs with a per-channel 2-FF synchroniser and a per-channel stability counter.
- Emits the clean level plus one-cycle rise/fall pulses per channel.
- Sits between board pins and the control FSMs. An optional tick input lets one shared prescaler set the debounce time base.

Parameters:
- NUM_CH, 4: number of independent input channels (1..32).
- STABLE_CNT, 2048: consecutive counted samples a new level must persist before it is accepted (>=2). Counter width = $clog2(STABLE_CNT).
- RST_VAL, 1'b0: value loaded into every db_out bit at reset.
- HOLD_CNT, 65536: counted samples of continuous high db_out before held asserts. Used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  sample strobe; counters advance only when tick=1. Tie to 1 for per-clock counting.
- btn_in  in  NUM_CH  raw asynchronous inputs.
- db_out  out  NUM_CH  debounced level.
- rise  out  NUM_CH  one-cycle pulse when db_out[i] goes 0->1.
- fall  out  NUM_CH  one-cycle pulse when db_out[i] goes 1->0.
- any_change  out  1  OR of all rise|fall bits, registered in the same cycle as the pulses.
- held  out  NUM_CH  long-press flag (LONG_PRESS_EN only).

Behaviour:
- Reset, when reset=1 at a clk edge:
  - sync FFs s1/s2 <= RST_VAL per bit.
  - all counters <= 0.
  - db_out <= RST_VAL.
  - rise, fall, any_change, held <= 0.
- Reset mid-operation abandons any count in progress. No pulse is emitted on reset exit.
- Synchroniser: s1[i] <= btn_in[i]; s2[i] <= s1[i]. Only s2 feeds the logic.
- Per channel, every clk edge, with priority top to bottom:
  - s2==db_out: cnt <= 0 (regardless of tick).
  - s2!=db_out, tick=1, cnt==STABLE_CNT-1: db_out <= s2; cnt <= 0; rise/fall asserted per direction for this one cycle.
  - s2!=db_out, tick=1: cnt <= cnt+1.
  - otherwise: cnt holds.
- rise/fall are registered, high for exactly one clk, and aligned with the db_out transition.
- Latency with tick tied high: input step to db_out change = STABLE_CNT+2 clk cycles.
- Any reversion of s2 to db_out before acceptance clears cnt. Glitches shorter than STABLE_CNT samples produce no output activity.
- Channels are fully independent. Simultaneous acceptance on several channels is allowed; any_change=1 for that single cycle.
- The counter never wraps: it clears at acceptance and saturates logically by acceptance. tick=0 freezes counts but not clears.

Optional Feature:
- Macro: MULTI_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of width $clog2(HOLD_CNT+1).
  - While db_out[i]=1, the counter increments on tick and saturates at HOLD_CNT.
  - held[i]=1 when the counter equals HOLD_CNT.
  - Counter and held clear in the same cycle db_out[i] falls, or on reset.
  - The held 0->1 transition occurs at most once per press.
- Undefined: the held port is still present, tied to 0. No hold counters are synthesised.

Test Plan:
- Common setup: NUM_CH=4, STABLE_CNT=4, RST_VAL=0, tick=1 unless noted.
- Reset with btn_in=4'hF, then release reset and hold btn_in=4'hF -> db_out=0 and no pulses until 6 clk later. Then db_out=4'hF, rise=4'hF and any_change=1 for one cycle.
- btn_in[0] 0->1 glitch held for 3 clk then back to 0 -> db_out, rise, fall stay 0 throughout.
- btn_in[2] steady 1 then 1->0 -> db_out[2] falls exactly 6 clk after the input edge. fall[2]=1 for one cycle only, rise=0.
- tick pulsed every 3rd clk, btn_in[1] 0->1 -> acceptance on the 4th tick after s2 changes. Pulse width is still 1 clk.
- reset asserted when cnt=3 on a pending channel -> db_out stays RST_VAL and no pulse. After release, a full 4-sample count is required.
- With MULTI_DEBOUNCE_LONG_PRESS_EN and HOLD_CNT=10:
  - hold btn_in[3]=1 -> held[3] rises 10 ticks after rise[3].
  - release -> held[3] clears in the same cycle as fall[3].

Source files
------------

// File: rtl/multi_debounce_if.sv
// Purpose : bundles the per-channel debounce inputs and outputs of multi_debounce.
// Ports   : tick/btn_in driven by the master (board/prescaler side);
//           db_out/rise/fall/any_change/held driven by the slave (debouncer).
interface multi_debounce_if #(
  parameter int NUM_CH = 4
);
  logic              tick;
  logic [NUM_CH-1:0] btn_in;
  logic [NUM_CH-1:0] db_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              any_change;
  logic [NUM_CH-1:0] held;

  modport master (
    output tick, btn_in,
    input  db_out, rise, fall, any_change, held
  );

  modport slave (
    input  tick, btn_in,
    output db_out, rise, fall, any_change, held
  );
endinterface

// File: rtl/multi_debounce.sv
// Purpose : NUM_CH-channel push-button debouncer: 2-FF synchroniser plus a stability
//           counter per channel, clean level and one-cycle rise/fall pulses.
// Latency : input step to db_out change = STABLE_CNT+2 clk with tick tied high;
//           no backpressure. Optional long-press flag via MULTI_DEBOUNCE_LONG_PRESS_EN.
// Ports   : i_clk, i_reset (sync, active high), bus (multi_debounce_if.slave).
module multi_debounce #(
  parameter int   NUM_CH     = 4,
  parameter int   STABLE_CNT = 2048,
  parameter logic RST_VAL    = 1'b0,
  parameter int   HOLD_CNT   = 65536
) (
  input  logic            i_clk,
  input  logic            i_reset,
  multi_debounce_if.slave bus
);

  localparam int            CW       = $clog2(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  if (NUM_CH < 1 || NUM_CH > 32 || STABLE_CNT < 2 || HOLD_CNT < 1) begin : g_bad_param
    $error("multi_debounce: parameter out of range");
  end

  logic [NUM_CH-1:0] r_s1;
  logic [NUM_CH-1:0] r_s2;
  logic [NUM_CH-1:0] r_db;
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_fall;
  logic              r_any;
  logic [CW-1:0]     r_cnt [NUM_CH];

  logic [NUM_CH-1:0] w_accept;
  logic [CW-1:0]     w_cnt_nxt [NUM_CH];

  // A channel accepts its new level on the counted sample that completes
  // STABLE_CNT consecutive disagreeing samples; any agreement clears the count.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_s2[i] == r_db[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (bus.tick) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_accept[i]  = 1'b1;
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1   <= {NUM_CH{RST_VAL}};
      r_s2   <= {NUM_CH{RST_VAL}};
      r_db   <= {NUM_CH{RST_VAL}};
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1   <= bus.btn_in;
      r_s2   <= r_s1;
      // Accepted channels flip; the accepted level is s2, which gives the direction.
      r_db   <= r_db ^ w_accept;
      r_rise <= w_accept & r_s2;
      r_fall <= w_accept & ~r_s2;
      r_any  <= |w_accept;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign bus.db_out     = r_db;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.any_change = r_any;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam int            HW       = $clog2(HOLD_CNT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT);

  logic [HW-1:0]     r_hcnt [NUM_CH];
  logic [NUM_CH-1:0] w_held;

  // Saturating at HOLD_MAX makes held assert at most once per press; the
  // clear is tied to the falling acceptance so held drops with fall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CH; i++) r_hcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_accept[i] && !r_s2[i]) begin
          r_hcnt[i] <= '0;
        end else if (r_db[i] && bus.tick && (r_hcnt[i] != HOLD_MAX)) begin
          r_hcnt[i] <= r_hcnt[i] + HW'(1);
        end
      end
    end
  end

  always_comb begin
    w_held = '0;
    for (int i = 0; i < NUM_CH; i++) w_held[i] = (r_hcnt[i] == HOLD_MAX);
  end

  assign bus.held = w_held;
`else
  assign bus.held = '0;
`endif

endmodule

// File: tb/tb_multi_debounce.sv
// Purpose : self-checking bench for multi_debounce (NUM_CH=4, STABLE_CNT=4, HOLD_CNT=10).
// Latency : one expectation record per clock, compared 1 ns after the rising edge.
// Stimulus: table rows {reset, btn, tick, repeat, expected outputs} plus a tick-strobe sequence.
module tb_multi_debounce;

  logic clk;
  logic reset;

  multi_debounce_if #(.NUM_CH(4)) bus ();

  multi_debounce #(
    .NUM_CH    (4),
    .STABLE_CNT(4),
    .RST_VAL   (1'b0),
    .HOLD_CNT  (10)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam logic [3:0] HM = 4'h8;
`else
  localparam logic [3:0] HM = 4'h0;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       tick;
    int         reps;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
    logic [3:0] held;
  } vec_t;

  typedef struct {
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
    logic [3:0] held;
  } exp_t;

  vec_t tbl [26];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;
  int   stepn = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, stepn, act, req);
    end
  endtask

  // Push the expectation, drive on the falling edge, compare just after the rising edge.
  task automatic step(input logic r, input logic [3:0] b, input logic t, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(negedge clk);
    reset      = r;
    bus.btn_in = b;
    bus.tick   = t;
    @(posedge clk);
    #1;
    stepn++;
    got = sb_q.pop_front();
    chk("db_out",     bus.db_out,             got.db);
    chk("rise",       bus.rise,               got.rise);
    chk("fall",       bus.fall,               got.fall);
    chk("any_change", {3'b000, bus.any_change}, {3'b000, got.any});
    chk("held",       bus.held,               got.held);
  endtask

  task automatic apply_row(input int idx);
    exp_t e;
    e.db   = tbl[idx].db;
    e.rise = tbl[idx].rise;
    e.fall = tbl[idx].fall;
    e.any  = tbl[idx].any;
    e.held = tbl[idx].held;
    for (int k = 0; k < tbl[idx].reps; k++) step(tbl[idx].rst, tbl[idx].btn, tbl[idx].tick, e);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    bus.btn_in = 4'h0;
    bus.tick   = 1'b1;

    //         rst   btn   tick reps db    rise  fall  any   held
    // reset with all inputs high, then the first acceptance 6 clk after release
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0};
    // 3-clk glitch on channel 0: count reaches 3 and is then cleared
    tbl[4]  = '{1'b1, 4'h0, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 4'h1, 1'b1, 3, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 6, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    // channel 2 press then release, fall exactly 6 clk after the input edge
    tbl[7]  = '{1'b0, 4'h4, 1'b1, 5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 4'h4, 1'b1, 1, 4'h4, 4'h4, 4'h0, 1'b1, 4'h0};
    tbl[9]  = '{1'b0, 4'h4, 1'b1, 3, 4'h4, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 5, 4'h4, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h4, 1'b1, 4'h0};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    // reset while channel 0 sits at count 3: no pulse, full count needed afterwards
    tbl[13] = '{1'b0, 4'h3, 1'b1, 5, 4'h2, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[14] = '{1'b1, 4'h3, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[15] = '{1'b0, 4'h3, 1'b1, 5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[16] = '{1'b0, 4'h3, 1'b1, 1, 4'h3, 4'h3, 4'h0, 1'b1, 4'h0};
    tbl[17] = '{1'b0, 4'h3, 1'b1, 1, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0};
    // long press on channel 3: held 10 clk after rise, clears together with fall
    tbl[18] = '{1'b1, 4'h0, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[19] = '{1'b0, 4'h8, 1'b1, 5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[20] = '{1'b0, 4'h8, 1'b1, 1, 4'h8, 4'h8, 4'h0, 1'b1, 4'h0};
    tbl[21] = '{1'b0, 4'h8, 1'b1, 9, 4'h8, 4'h0, 4'h0, 1'b0, 4'h0};
    tbl[22] = '{1'b0, 4'h8, 1'b1, 4, 4'h8, 4'h0, 4'h0, 1'b0, HM};
    tbl[23] = '{1'b0, 4'h0, 1'b1, 5, 4'h8, 4'h0, 4'h0, 1'b0, HM};
    tbl[24] = '{1'b0, 4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h8, 1'b1, 4'h0};
    tbl[25] = '{1'b0, 4'h0, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};

    for (int r = 0; r <= 12; r++) apply_row(r);

    // tick on every 3rd clk: s2 settles after clk 2, counted samples land on
    // clks 3, 6, 9 and the 4th (clk 12) accepts; the pulse is still 1 clk wide.
    for (int k = 1; k <= 14; k++) begin
      e.db   = (k >= 12) ? 4'h2 : 4'h0;
      e.rise = (k == 12) ? 4'h2 : 4'h0;
      e.fall = 4'h0;
      e.any  = (k == 12);
      e.held = 4'h0;
      step(1'b0, 4'h2, (k % 3) == 0, e);
    end

    for (int r = 13; r <= 25; r++) apply_row(r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
